rs_sched: RTL and testbench
===========================

# rs_sched

Allocation and issue controller for a bank of `NUM_RS` reservation-station entries sharing one functional unit. It replaces the serial claim chain with explicit control:
- on dispatch, it picks the lowest free entry and returns a one-hot load strobe to that entry;
- on issue, it round-robins among entries whose operands are resolved;
- it holds a registered grant until the FU accepts it.

It stores no operand data; the RS entries keep their payload and drive the FU mux from `issue_grant`.

## Interface
Parameters:
- `NUM_RS`, 4: number of RS entries managed, 2..16.
- `CNT_W`, `$clog2(NUM_RS+1)`: occupancy count width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: pipeline flush; synchronous, kills all entries.
- `disp_valid` in 1: decode has an instruction to place.
- `disp_ready` out 1: a free entry exists and no flush is active.
- `alloc` out NUM_RS: one-hot load strobe to the chosen entry; drives that entry's capture enable.
- `slot_ready` in NUM_RS: per-entry "both deps locked".
- `issue_valid` out 1: a registered grant is presented to the FU.
- `issue_grant` out NUM_RS: one-hot grant; selects the entry's payload onto the FU bus.
- `issue_slot` out `$clog2(NUM_RS)`: binary index of `issue_grant`.
- `fu_ready` in 1: FU accepts this cycle.
- `issue_release` out NUM_RS: one-hot pulse telling the granted entry to clear.
- `occupancy` out CNT_W: number of busy entries.
- `rs_full` out 1: `occupancy == NUM_RS`.
- `rs_empty` out 1: `occupancy == 0`.

## Operation
- **State per entry:** `busy[i]`. Global state: `rr_ptr`, FSM `{IDLE, ISSUE}`, `grant_q`.
- **Dispatch:**
  - `disp_ready = ~flush & ~&busy`.
  - `alloc` is lowest-index `i` with `busy[i]==0`, gated by `disp_valid & disp_ready`; otherwise all zero.
  - `busy[i]` sets at the next edge.
- **IDLE:**
  - `cand = busy & slot_ready`. `slot_ready` on a non-busy entry is ignored.
  - If `cand != 0`, pick the first set bit at or after `rr_ptr`, circularly, into `grant_q`, then go to ISSUE.
- **ISSUE:**
  - `issue_valid=1` and `issue_grant=grant_q`; both are held stable while `fu_ready=0`.
  - When `fu_ready=1`: `issue_release=grant_q` for that cycle; `busy[g]` clears; `rr_ptr` becomes `(g+1) mod NUM_RS`, wrapping `NUM_RS-1→0`; go to IDLE.
- **Simultaneous events:**
  - Alloc and release in the same cycle act on different entries; occupancy is unchanged.
  - A released entry becomes allocatable the following cycle, never the same cycle.
- **Flush:**
  - At the edge, all `busy` clear, FSM goes to IDLE, `grant_q` clears. `rr_ptr` is held.
  - While `flush=1`: `disp_ready=0`, `alloc=0`, and `issue_valid` is forced to 0 combinationally.
  - `issue_release` is 0, because the FU must not consume a flushed op.
- **Occupancy:** `occupancy` equals the popcount of `busy`, kept as a registered counter, ±1 per event. A bench assertion checks counter == popcount.
- **Reset values:**
  - All outputs 0 except `rs_empty=1` and `disp_ready=1`; `disp_ready` is 0 while `rst` is high.
  - `busy=0`, `rr_ptr=0`, FSM=IDLE.

## Timing
- `alloc` is combinational from `disp_valid` and `busy`, same cycle.
- Dispatch to earliest `issue_valid`: 2 cycles, with alloc in cycle 0. In cycle 1, busy and `slot_ready` are both seen; `issue_valid` asserts in cycle 2.
- `issue_valid` and `issue_grant` are registered.
- `issue_release` is combinational: `issue_valid & fu_ready & ~flush`.
- Back-to-back issue: at most one grant every 2 cycles, because the FSM returns to IDLE for one cycle.
- Reset mid-ISSUE asynchronously drops `issue_valid`; no release pulse is generated.

## Structure
- **Package `rs_pkg`:** `sched_state_t` enum `{IDLE, ISSUE}` and a `NUM_RS_DEFAULT` constant.
- **Sub-module `rr_arbiter`:** parameterized by N. Inputs: request vector and pointer. Output: one-hot grant. Purely combinational.
- **Top-level logic:** the FSM, busy vector, counter and lowest-free priority encoder stay in `rs_sched`.

## Test plan
All scenarios use `NUM_RS=4`.
- **Fill and full:** `disp_valid` held 4 cycles from reset → `alloc` 0001, 0010, 0100, 1000; `rs_full=1`, `disp_ready=0`, `occupancy=4`.
- **Round-robin:** all 4 entries busy, `slot_ready=1111`, `fu_ready=1` → grants 0001, 0010, 0100, 1000, each 2 cycles apart; `rr_ptr` wraps to 0.
- **FU stall:** grant 0100 with `fu_ready=0` for 5 cycles → `issue_grant` stable, no `issue_release`; `fu_ready` high → one release pulse, busy clears the next cycle.
- **Simultaneous:** release entry 0 while allocating entry 2 → `occupancy` unchanged at 3; entry 0 is allocatable the next cycle.
- **Flush mid-ISSUE:** flush with grant 0010 pending and `fu_ready=1` → `issue_valid=0`, no release; next cycle `occupancy=0`, `rs_empty=1`.
- **Async reset:** assert `rst` between clock edges during ISSUE → outputs reach reset values immediately; `alloc` restarts at 0001.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation-station scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs_pkg;

  // Scheduler FSM: IDLE looks for a ready entry, ISSUE holds a grant for the FU.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  localparam int NUM_RS_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, circularly.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is all-zero when req is all-zero.
//
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority index this cycle
//   grant out N      one-hot grant (or zero)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk N positions starting at ptr; the modulo makes the scan wrap N-1 -> 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_sched.sv
// Allocation and issue controller for NUM_RS reservation-station entries sharing one FU.
// Latency: alloc is same-cycle; dispatch-to-issue_valid is 2 cycles; one grant per 2 cycles max.
// Backpressure: disp_ready drops when full or flushing; grant is held until fu_ready.
//
// Ports:
//   clk, rst (async, active-high), flush (sync kill of all entries)
//   disp_valid/disp_ready, alloc        : dispatch handshake and one-hot capture strobe
//   slot_ready                          : per-entry operands-resolved
//   issue_valid, issue_grant, issue_slot: registered grant presented to the FU
//   fu_ready, issue_release             : FU accept and one-hot entry-clear pulse
//   occupancy, rs_full, rs_empty        : busy-entry count and its limits
module rs_sched
  import rs_pkg::*;
#(
  parameter int NUM_RS = NUM_RS_DEFAULT,
  parameter int CNT_W  = $clog2(NUM_RS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  output logic [NUM_RS-1:0]          alloc,
  input  logic [NUM_RS-1:0]          slot_ready,
  output logic                       issue_valid,
  output logic [NUM_RS-1:0]          issue_grant,
  output logic [$clog2(NUM_RS)-1:0]  issue_slot,
  input  logic                       fu_ready,
  output logic [NUM_RS-1:0]          issue_release,
  output logic [CNT_W-1:0]           occupancy,
  output logic                       rs_full,
  output logic                       rs_empty
);

  localparam int IDX_W = $clog2(NUM_RS);

  sched_state_t      state_q;
  logic [NUM_RS-1:0] busy_q, busy_d;
  logic [NUM_RS-1:0] grant_q;
  logic [NUM_RS-1:0] free_first, cand, arb_grant;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, slot;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              free_found, alloc_any, rel_any;

  // Lowest-index free entry.
  always_comb begin
    free_first = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_first[i] = 1'b1;
        free_found    = 1'b1;
      end
    end
  end

  // rst gating keeps disp_ready low for the whole reset pulse, not just after the edge.
  assign disp_ready = ~rst & ~flush & ~(&busy_q);
  assign alloc_any  = disp_valid & disp_ready;
  assign alloc      = alloc_any ? free_first : '0;

  // Only busy entries may compete; slot_ready on a free entry is stale.
  assign cand = busy_q & slot_ready;

  rr_arbiter #(
    .N     (NUM_RS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (cand),
    .ptr   (rr_ptr_q),
    .grant (arb_grant)
  );

  // Binary index of the held grant.
  always_comb begin
    slot = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant_q[i]) slot = slot | IDX_W'(i);
    end
  end

  // Flush masks the presented grant so the FU never consumes a killed op.
  assign issue_valid   = (state_q == ISSUE) & ~flush;
  assign issue_grant   = grant_q;
  assign issue_slot    = slot;
  assign rel_any       = issue_valid & fu_ready;
  assign issue_release = rel_any ? grant_q : '0;

  // Alloc uses busy_q, so a releasing entry is still busy and cannot be re-picked this cycle.
  always_comb begin
    busy_d   = flush ? '0 : ((busy_q | alloc) & ~issue_release);
    cnt_d    = flush ? '0 : (cnt_q + CNT_W'(alloc_any) - CNT_W'(rel_any));
    rr_ptr_d = rr_ptr_q;
    if (rel_any) begin
      rr_ptr_d = (slot == IDX_W'(NUM_RS - 1)) ? '0 : slot + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      if (flush) begin
        state_q <= IDLE;
        grant_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|cand) begin
              grant_q <= arb_grant;
              state_q <= ISSUE;
            end
          end
          ISSUE: begin
            if (fu_ready) begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
          default: begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign occupancy = cnt_q;
  assign rs_full   = (cnt_q == CNT_W'(NUM_RS));
  assign rs_empty  = (cnt_q == '0);

endmodule

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched with NUM_RS=4.
// Latency: inputs driven 1 time unit after posedge, outputs sampled shortly after.
// Backpressure: fu_ready and disp_valid driven directly per scenario.
module tb_rs_sched;

  localparam int NUM_RS = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [NUM_RS-1:0] alloc;
  logic [NUM_RS-1:0] slot_ready;
  logic              issue_valid;
  logic [NUM_RS-1:0] issue_grant;
  logic [1:0]        issue_slot;
  logic              fu_ready;
  logic [NUM_RS-1:0] issue_release;
  logic [CNT_W-1:0]  occupancy;
  logic              rs_full;
  logic              rs_empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_sched #(.NUM_RS(NUM_RS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .alloc         (alloc),
    .slot_ready    (slot_ready),
    .issue_valid   (issue_valid),
    .issue_grant   (issue_grant),
    .issue_slot    (issue_slot),
    .fu_ready      (fu_ready),
    .issue_release (issue_release),
    .occupancy     (occupancy),
    .rs_full       (rs_full),
    .rs_empty      (rs_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy counter must always equal the popcount of the busy vector.
  always @(negedge clk) begin
    if (!rst) check("occ_popcount", 32'(occupancy), 32'($countones(dut.busy_q)));
  end

  task automatic fill();
    disp_valid = 1'b1;
    for (int i = 0; i < NUM_RS; i++) begin
      #1;
      check("fill_alloc", 32'(alloc), 32'(1 << i));
      check("fill_rdy", 32'(disp_ready), 32'd1);
      step();
    end
    #1;
    check("full_flag", 32'(rs_full), 32'd1);
    check("full_rdy", 32'(disp_ready), 32'd0);
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_alloc", 32'(alloc), 32'd0);
    disp_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    disp_valid = 1'b0;
    slot_ready = '0;
    fu_ready   = 1'b0;
    #2;
    check("rst_rdy_low", 32'(disp_ready), 32'd0);
    check("rst_empty", 32'(rs_empty), 32'd1);
    check("rst_iv", 32'(issue_valid), 32'd0);
    #5 rst = 1'b0;
    step();
    check("rst_rdy", 32'(disp_ready), 32'd1);
    check("rst_empty2", 32'(rs_empty), 32'd1);
    check("rst_full", 32'(rs_full), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_grant", 32'(issue_grant), 32'd0);
    check("rst_rel", 32'(issue_release), 32'd0);
    step();

    // Fill and full
    fill();

    // Round-robin over all four, one grant every 2 cycles
    slot_ready = 4'b1111;
    fu_ready   = 1'b1;
    #1;
    check("rr_idle", 32'(issue_valid), 32'd0);
    for (int k = 0; k < NUM_RS; k++) begin
      step();
      check("rr_iv", 32'(issue_valid), 32'd1);
      check("rr_grant", 32'(issue_grant), 32'(1 << k));
      check("rr_slot", 32'(issue_slot), 32'(k));
      check("rr_rel", 32'(issue_release), 32'(1 << k));
      step();
      check("rr_gap", 32'(issue_valid), 32'd0);
      check("rr_occ", 32'(occupancy), 32'(3 - k));
    end
    check("rr_empty", 32'(rs_empty), 32'd1);
    slot_ready = '0;
    fu_ready   = 1'b0;
    step();

    // FU stall on entry 2
    fill();
    slot_ready = 4'b0100;
    #1;
    check("stall_idle", 32'(issue_valid), 32'd0);
    for (int s = 0; s < 5; s++) begin
      step();
      check("stall_iv", 32'(issue_valid), 32'd1);
      check("stall_grant", 32'(issue_grant), 32'b0100);
      check("stall_norel", 32'(issue_release), 32'd0);
    end
    fu_ready = 1'b1;
    #1;
    check("stall_rel", 32'(issue_release), 32'b0100);
    step();
    fu_ready   = 1'b0;
    slot_ready = '0;
    #1;
    check("stall_after_iv", 32'(issue_valid), 32'd0);
    check("stall_after_rel", 32'(issue_release), 32'd0);
    check("stall_after_occ", 32'(occupancy), 32'd3);

    // Simultaneous: busy=1011, rr=3 -> circular pick of entry 0, alloc entry 2
    slot_ready = 4'b0001;
    step();
    check("sim_grant_wrap", 32'(issue_grant), 32'b0001);
    disp_valid = 1'b1;
    fu_ready   = 1'b1;
    #1;
    check("sim_alloc", 32'(alloc), 32'b0100);
    check("sim_rel", 32'(issue_release), 32'b0001);
    check("sim_occ", 32'(occupancy), 32'd3);
    step();
    fu_ready   = 1'b0;
    slot_ready = '0;
    #1;
    check("sim_occ_next", 32'(occupancy), 32'd3);
    check("sim_realloc", 32'(alloc), 32'b0001);
    step();
    disp_valid = 1'b0;
    #1;
    check("sim_full", 32'(rs_full), 32'd1);

    // Flush with grant 0010 pending and fu_ready high
    slot_ready = 4'b0010;
    step();
    check("fl_grant", 32'(issue_grant), 32'b0010);
    check("fl_iv_pre", 32'(issue_valid), 32'd1);
    step();
    flush      = 1'b1;
    fu_ready   = 1'b1;
    disp_valid = 1'b1;
    #1;
    check("fl_iv", 32'(issue_valid), 32'd0);
    check("fl_rel", 32'(issue_release), 32'd0);
    check("fl_alloc", 32'(alloc), 32'd0);
    check("fl_rdy", 32'(disp_ready), 32'd0);
    step();
    flush      = 1'b0;
    fu_ready   = 1'b0;
    disp_valid = 1'b0;
    slot_ready = '0;
    #1;
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_empty", 32'(rs_empty), 32'd1);
    check("fl_grant_clr", 32'(issue_grant), 32'd0);

    // Async reset mid-ISSUE
    disp_valid = 1'b1;
    #1;
    check("ar_alloc", 32'(alloc), 32'b0001);
    step();
    disp_valid = 1'b0;
    slot_ready = 4'b0001;
    step();
    check("ar_iv_pre", 32'(issue_valid), 32'd1);
    check("ar_grant_pre", 32'(issue_grant), 32'b0001);
    #1 rst = 1'b1;
    #1;
    check("ar_iv", 32'(issue_valid), 32'd0);
    check("ar_grant", 32'(issue_grant), 32'd0);
    check("ar_rel", 32'(issue_release), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_empty", 32'(rs_empty), 32'd1);
    check("ar_rdy", 32'(disp_ready), 32'd0);
    #2;
    rst        = 1'b0;
    slot_ready = '0;
    disp_valid = 1'b1;
    #1;
    check("ar_restart", 32'(alloc), 32'b0001);
    check("ar_rdy_after", 32'(disp_ready), 32'd1);
    step();
    disp_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
